// File: rtl/process_ready_queue.sv
// Ready queue of runnable process descriptors.
// Pops the head into an idle core with a one-cycle start pulse.
module process_ready_queue #(
  parameter int addrBits  = 16,
  parameter int pcBits    = 9,
  parameter int depthLog2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enqValid,
  output logic                enqReady,
  input  logic [pcBits-1:0]   enqPc,
  input  logic [addrBits-1:0] enqStack,
  input  logic                dispatchEnable,
  input  logic                core0Idle,
  input  logic                core1Idle,
  output logic                core0Start,
  output logic [pcBits-1:0]   core0StartPc,
  output logic [addrBits-1:0] core0StartStack,
  output logic                core1Start,
  output logic [pcBits-1:0]   core1StartPc,
  output logic [addrBits-1:0] core1StartStack,
  output logic [depthLog2:0]  count,
  output logic                empty,
  output logic                full
);

  localparam int DEPTH = 1 << depthLog2;
  localparam int W     = pcBits + addrBits;

  typedef enum logic [1:0] {
    AVAIL   = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } st_t;

  logic [W-1:0]          r_mem [DEPTH];
  logic [depthLog2-1:0]  r_head;
  logic [depthLog2-1:0]  r_tail;
  logic [depthLog2:0]    r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_grant;
  st_t                   r_st0, r_st1;
  st_t                   w_nx0, w_nx1;
  logic [pcBits-1:0]     r_pc0, r_pc1;
  logic [addrBits-1:0]   r_stk0, r_stk1;

  logic                  w_enq;
  logic                  w_e0, w_e1;
  logic                  w_pop;
  logic                  w_sel1;
  logic                  w_go0, w_go1;
  logic [W-1:0]          w_head;
  logic [depthLog2:0]    w_cnt_nx;

  assign w_enq  = enqValid && !r_full;
  assign w_e0   = (r_st0 == AVAIL) && core0Idle;
  assign w_e1   = (r_st1 == AVAIL) && core1Idle;
  assign w_pop  = dispatchEnable && !r_empty && (w_e0 || w_e1);
  assign w_sel1 = w_e1 && (!w_e0 || r_grant);
  assign w_go0  = w_pop && !w_sel1;
  assign w_go1  = w_pop && w_sel1;
  assign w_head = r_mem[r_head];

  always_comb begin
    w_cnt_nx = r_count;
    if (w_enq && !w_pop)
      w_cnt_nx = r_count + 1'b1;
    else if (!w_enq && w_pop)
      w_cnt_nx = r_count - 1'b1;
  end

  // Storage is not reset; entries are discarded by clearing the pointers.
  always_ff @(posedge clk) begin
    if (w_enq)
      r_mem[r_tail] <= {enqPc, enqStack};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_grant <= 1'b0;
    end else begin
      if (w_enq)
        r_tail <= r_tail + 1'b1;
      if (w_pop) begin
        r_head  <= r_head + 1'b1;
        r_grant <= ~r_grant;
      end
      r_count <= w_cnt_nx;
      r_empty <= (w_cnt_nx == '0);
      r_full  <= (w_cnt_nx == DEPTH[depthLog2:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc0  <= '0;
      r_stk0 <= '0;
      r_pc1  <= '0;
      r_stk1 <= '0;
    end else begin
      if (w_go0) begin
        r_pc0  <= w_head[W-1:addrBits];
        r_stk0 <= w_head[addrBits-1:0];
      end
      if (w_go1) begin
        r_pc1  <= w_head[W-1:addrBits];
        r_stk1 <= w_head[addrBits-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_st0 <= AVAIL;
      r_st1 <= AVAIL;
    end else begin
      r_st0 <= w_nx0;
      r_st1 <= w_nx1;
    end
  end

  // HOLDOFF masks the core for one cycle while its idle flag catches up.
  always_comb begin
    w_nx0 = r_st0;
    unique case (r_st0)
      AVAIL:   if (w_go0) w_nx0 = PULSE;
      PULSE:   w_nx0 = HOLDOFF;
      HOLDOFF: w_nx0 = AVAIL;
      default: w_nx0 = AVAIL;
    endcase
  end

  always_comb begin
    w_nx1 = r_st1;
    unique case (r_st1)
      AVAIL:   if (w_go1) w_nx1 = PULSE;
      PULSE:   w_nx1 = HOLDOFF;
      HOLDOFF: w_nx1 = AVAIL;
      default: w_nx1 = AVAIL;
    endcase
  end

  always_comb begin
    core0Start      = (r_st0 == PULSE);
    core1Start      = (r_st1 == PULSE);
    core0StartPc    = r_pc0;
    core0StartStack = r_stk0;
    core1StartPc    = r_pc1;
    core1StartStack = r_stk1;
    enqReady        = !r_full;
    count           = r_count;
    empty           = r_empty;
    full            = r_full;
  end

endmodule

// File: tb/tb_process_ready_queue.sv
// Directed bench for process_ready_queue.
// Start pulses are checked against a scoreboard of expected dispatches.
module tb_process_ready_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        enqValid;
  logic        enqReady;
  logic [8:0]  enqPc;
  logic [15:0] enqStack;
  logic        dispatchEnable;
  logic        core0Idle;
  logic        core1Idle;
  logic        core0Start;
  logic [8:0]  core0StartPc;
  logic [15:0] core0StartStack;
  logic        core1Start;
  logic [8:0]  core1StartPc;
  logic [15:0] core1StartStack;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  typedef struct {
    bit          core;
    logic [8:0]  pc;
    logic [15:0] stk;
  } exp_t;

  exp_t sb[$];
  int   t0q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  process_ready_queue dut (
    .clk            (clk),
    .reset          (reset),
    .enqValid       (enqValid),
    .enqReady       (enqReady),
    .enqPc          (enqPc),
    .enqStack       (enqStack),
    .dispatchEnable (dispatchEnable),
    .core0Idle      (core0Idle),
    .core1Idle      (core1Idle),
    .core0Start     (core0Start),
    .core0StartPc   (core0StartPc),
    .core0StartStack(core0StartStack),
    .core1Start     (core1Start),
    .core1StartPc   (core1StartPc),
    .core1StartStack(core1StartStack),
    .count          (count),
    .empty          (empty),
    .full           (full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic got_pulse(input bit core, input logic [8:0] pc,
                           input logic [15:0] stk);
    exp_t e;
    chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("pulse_core", 32'(core), 32'(e.core));
      chk("pulse_pc", 32'(pc), 32'(e.pc));
      chk("pulse_stack", 32'(stk), 32'(e.stk));
    end
    if (core == 1'b0)
      t0q.push_back(cyc);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (core0Start) got_pulse(1'b0, core0StartPc, core0StartStack);
      if (core1Start) got_pulse(1'b1, core1StartPc, core1StartStack);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic enq(input logic [8:0] pc, input logic [15:0] stk,
                     input bit push, input bit core);
    exp_t e;
    enqValid = 1'b1;
    enqPc    = pc;
    enqStack = stk;
    if (push) begin
      e.core = core;
      e.pc   = pc;
      e.stk  = stk;
      sb.push_back(e);
    end
    step();
    enqValid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      step();
      k++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    repeat (4) step();
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    reset          = 1'b0;
    enqValid       = 1'b0;
    enqPc          = '0;
    enqStack       = '0;
    dispatchEnable = 1'b0;
    core0Idle      = 1'b1;
    core1Idle      = 1'b1;
    step();
    do_reset();

    // reset state, then idle with dispatch on: no pulses allowed
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_enqReady", 32'(enqReady), 32'd1);
    chk("rst_start0", 32'(core0Start), 32'd0);
    chk("rst_start1", 32'(core1Start), 32'd0);
    chk("rst_pc0", 32'(core0StartPc), 32'd0);
    chk("rst_stk1", 32'(core1StartStack), 32'd0);
    dispatchEnable = 1'b1;
    repeat (20) step();
    chk("idle_count", 32'(count), 32'd0);

    // single dispatch to core 0
    enq(9'h010, 16'h0100, 1'b1, 1'b0);
    drain("single");

    // fill to full, drop 9th, alternate cores on drain
    do_reset();
    dispatchEnable = 1'b0;
    for (int i = 0; i < 8; i++)
      enq(9'(9'h20 + i), 16'(16'h1000 + i), 1'b1, 1'(i % 2));
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_enqReady", 32'(enqReady), 32'd0);
    enq(9'h1FF, 16'hFFFF, 1'b0, 1'b0);
    chk("drop_count", 32'(count), 32'd8);
    dispatchEnable = 1'b1;
    drain("alt");

    // only core 0 idle: one pulse every third cycle
    do_reset();
    dispatchEnable = 1'b0;
    core1Idle      = 1'b0;
    for (int i = 0; i < 3; i++)
      enq(9'(9'h40 + i), 16'(16'h2000 + i), 1'b1, 1'b0);
    t0q.delete();
    dispatchEnable = 1'b1;
    drain("core0only");
    chk("core0only_npulse", 32'(t0q.size()), 32'd3);
    if (t0q.size() == 3) begin
      chk("core0only_gap1", 32'(t0q[1] - t0q[0]), 32'd3);
      chk("core0only_gap2", 32'(t0q[2] - t0q[1]), 32'd3);
    end
    core1Idle = 1'b1;

    // pointer wrap: 6 in, 6 out, then 5 more across the wrap
    do_reset();
    dispatchEnable = 1'b0;
    for (int i = 1; i <= 6; i++)
      enq(9'(i), 16'(16'h3000 + i), 1'b1, 1'((i - 1) % 2));
    dispatchEnable = 1'b1;
    drain("wrap_a");
    dispatchEnable = 1'b0;
    for (int i = 7; i <= 11; i++)
      enq(9'(i), 16'(16'h3000 + i), 1'b1, 1'((i - 7) % 2));
    chk("wrap_count5", 32'(count), 32'd5);
    dispatchEnable = 1'b1;
    drain("wrap_b");

    // reset while entries queued and a dispatch decision is due
    do_reset();
    dispatchEnable = 1'b0;
    for (int i = 0; i < 4; i++)
      enq(9'(9'h60 + i), 16'(16'h4000 + i), 1'b0, 1'b0);
    chk("mid_count4", 32'(count), 32'd4);
    dispatchEnable = 1'b1;
    reset          = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_count0", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_start0", 32'(core0Start), 32'd0);
    chk("mid_start1", 32'(core1Start), 32'd0);
    repeat (10) step();
    chk("mid_after_count", 32'(count), 32'd0);
    chk("mid_sb", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
